// File: rtl/xge_pkt_gen.sv
// Test-traffic generator for the 10G tester: drives the MAC pkt_tx_* interface with
// frames made of a header word (seq, len, marker) followed by Galois PRBS payload.
module xge_pkt_gen #(
   parameter int          MIN_LEN = 64,
   parameter int          MAX_LEN = 9600,
   parameter logic [15:0] MARKER  = 16'hA55A
) (
   input  logic        clk_156,
   input  logic        reset_156,
   input  logic        start,
   input  logic        stop,
   input  logic [13:0] frame_len,
   input  logic [7:0]  ifg_cycles,
   input  logic [31:0] pkt_count,
   input  logic [31:0] seed,
   input  logic        pkt_tx_full,
   output logic [63:0] pkt_tx_data,
   output logic        pkt_tx_val,
   output logic        pkt_tx_sop,
   output logic        pkt_tx_eop,
   output logic [2:0]  pkt_tx_mod,
   output logic        busy,
   output logic        done,
   output logic [31:0] sent_pkts,
   output logic [47:0] sent_bytes
);
   typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_GAP} state_t;

   localparam logic [13:0] MIN_LEN_W = 14'(MIN_LEN);
   localparam logic [13:0] MAX_LEN_W = 14'(MAX_LEN);
   localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

   state_t      r_state;
   logic [13:0] r_len;
   logic [7:0]  r_ifg;
   logic [31:0] r_pkt_count;
   logic [63:0] r_lfsr;
   logic [31:0] r_seq;
   logic        r_stop_req;
   logic [10:0] r_word_cnt;
   logic [7:0]  r_gap_cnt;
   logic [63:0] r_data;
   logic        r_val;
   logic        r_sop;
   logic        r_eop;
   logic [2:0]  r_mod;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_sent_pkts;
   logic [47:0] r_sent_bytes;

   logic [13:0] w_len_clamped;
   logic [10:0] w_nwords;
   logic        w_last_word;
   logic        w_run_end;
   logic [63:0] w_lfsr_next;
   logic [63:0] w_eop_mask;

   assign w_len_clamped = (frame_len < MIN_LEN_W) ? MIN_LEN_W :
                          (frame_len > MAX_LEN_W) ? MAX_LEN_W : frame_len;
   assign w_nwords      = 11'((15'(r_len) + 15'd7) >> 3);
   assign w_last_word   = (r_word_cnt == w_nwords - 11'd1);
   assign w_run_end     = r_stop_req ||
                          ((r_pkt_count != 32'd0) && (r_sent_pkts + 32'd1 == r_pkt_count));
   assign w_lfsr_next   = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 64'd0);
   // Keeps the top len[2:0] bytes of the eop word; zero mod means all eight are valid.
   assign w_eop_mask    = (r_len[2:0] == 3'd0) ? {64{1'b1}} :
                          ~({64{1'b1}} >> {r_len[2:0], 3'b000});

   always_ff @(posedge clk_156) begin
      if (reset_156) begin
         r_state      <= S_IDLE;
         r_len        <= '0;
         r_ifg        <= '0;
         r_pkt_count  <= '0;
         r_lfsr       <= '0;
         r_seq        <= '0;
         r_stop_req   <= 1'b0;
         r_word_cnt   <= '0;
         r_gap_cnt    <= '0;
         r_data       <= '0;
         r_val        <= 1'b0;
         r_sop        <= 1'b0;
         r_eop        <= 1'b0;
         r_mod        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_sent_pkts  <= '0;
         r_sent_bytes <= '0;
      end else begin
         // NOTE: per-cycle outputs default to 0 here; a later non-blocking assignment in the case overrides.
         r_data <= '0;
         r_val  <= 1'b0;
         r_sop  <= 1'b0;
         r_eop  <= 1'b0;
         r_mod  <= '0;
         r_done <= 1'b0;
         if (stop && (r_state != S_IDLE)) r_stop_req <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_len        <= w_len_clamped;
                  r_ifg        <= ifg_cycles;
                  r_pkt_count  <= pkt_count;
                  r_lfsr       <= {seed, ~seed};
                  r_seq        <= '0;
                  r_sent_pkts  <= '0;
                  r_sent_bytes <= '0;
                  r_stop_req   <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= S_HDR;
               end
            end
            S_HDR: begin
               if (!pkt_tx_full) begin
                  r_data     <= {r_seq, 2'b00, r_len, MARKER};
                  r_val      <= 1'b1;
                  r_sop      <= 1'b1;
                  r_word_cnt <= 11'd1;
                  r_state    <= S_BODY;
               end
            end
            S_BODY: begin
               if (!pkt_tx_full) begin
                  r_val      <= 1'b1;
                  r_data     <= r_lfsr;
                  r_lfsr     <= w_lfsr_next;
                  r_word_cnt <= r_word_cnt + 11'd1;
                  if (w_last_word) begin
                     r_eop        <= 1'b1;
                     r_mod        <= r_len[2:0];
                     r_data       <= r_lfsr & w_eop_mask;
                     r_sent_pkts  <= r_sent_pkts + 32'd1;
                     r_sent_bytes <= r_sent_bytes + 48'(r_len);
                     r_seq        <= r_seq + 32'd1;
                     if (w_run_end) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else if (r_ifg != 8'd0) begin
                        r_gap_cnt <= r_ifg;
                        r_state   <= S_GAP;
                     end else begin
                        r_state <= S_HDR;
                     end
                  end
               end
            end
            S_GAP: begin
               if (!pkt_tx_full) begin
                  r_gap_cnt <= r_gap_cnt - 8'd1;
                  if (r_gap_cnt == 8'd1) r_state <= S_HDR;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign pkt_tx_data = r_data;
   assign pkt_tx_val  = r_val;
   assign pkt_tx_sop  = r_sop;
   assign pkt_tx_eop  = r_eop;
   assign pkt_tx_mod  = r_mod;
   assign busy        = r_busy;
   assign done        = r_done;
   assign sent_pkts   = r_sent_pkts;
   assign sent_bytes  = r_sent_bytes;

endmodule
